// File: rtl/snn_infer_ctrl.sv
// -----------------------------------------------------------------------------
// snn_infer_ctrl
//
// Host-side controller for a spiking-neural-network digit classifier.
// The host fills a 256-entry pixel store through a simple register write port,
// then writes START. The controller streams every pixel to the SNN over a
// valid/ready channel, waits for the coprocessor to go busy and idle again,
// and latches the inferred digit into STATUS. A cycle counter aborts an
// inference that never completes.
//
// Ports
//   ACLK, ARESETN       clock (rising edge), asynchronous active-low reset
//   REG_WE              1-cycle write strobe
//   REG_ADDR[8:0]       0..N_PIX-1 pixel word, 256 control word, others ignored
//   REG_WDATA[31:0]     pixel value in [7:0]; control: bit0 START, bit1 CLEAR
//   RES_RD              host has consumed the result (clears RES_VALID)
//   STATUS[31:0]        [7:0] digit, [8] RES_VALID, [9] BUSY, [10] ERR,
//                       [11] IMG_FULL, [12] TIMEOUT_FLAG, [31:13] zero
//   SNN_START           1-cycle pulse at the first stream cycle
//   PIX_VALID/IDX/VAL   pixel stream towards the SNN
//   PIX_READY           SNN accepts the current pixel
//   COPROCESSOR_RDY     SNN idle (low while inferring)
//   INFERED_DIGIT[7:0]  SNN result, sampled when COPROCESSOR_RDY returns high
// -----------------------------------------------------------------------------
module snn_infer_ctrl #(
    parameter int N_PIX   = 256,
    parameter int TIMEOUT = 65535
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        REG_WE,
    input  logic [8:0]  REG_ADDR,
    input  logic [31:0] REG_WDATA,
    input  logic        RES_RD,
    output logic [31:0] STATUS,
    output logic        SNN_START,
    output logic        PIX_VALID,
    output logic [7:0]  PIX_IDX,
    output logic [7:0]  PIX_VAL,
    input  logic        PIX_READY,
    input  logic        COPROCESSOR_RDY,
    input  logic [7:0]  INFERED_DIGIT
);

    localparam logic [7:0]  LAST_IDX = 8'(N_PIX - 1);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_WAIT, ST_DONE} state_t;

    state_t           state_q, state_d;
    logic [7:0]       img_mem [N_PIX];
    logic [N_PIX-1:0] mask_q, mask_d;
    logic [7:0]       digit_q, digit_d;
    logic             res_valid_q, res_valid_d;
    logic             err_q, err_d;
    logic             to_flag_q, to_flag_d;
    logic             snn_start_q, snn_start_d;
    logic [7:0]       pix_idx_q, pix_idx_d;
    logic [7:0]       pix_val_q;
    logic [15:0]      cnt_q, cnt_d;
    logic             seen_low_q, seen_low_d;

    logic       pix_wr, ctrl_wr, start_req, clear_req;
    logic       img_we, img_full, busy;
    logic       rd_en;
    logic [7:0] rd_addr;
    logic       unused_wdata;

    assign pix_wr    = REG_WE && (32'(REG_ADDR) < 32'(N_PIX));
    assign ctrl_wr   = REG_WE && (REG_ADDR == 9'd256);
    assign clear_req = ctrl_wr && REG_WDATA[1];
    // CLEAR in the same word discards START.
    assign start_req = ctrl_wr && REG_WDATA[0] && !REG_WDATA[1];
    assign img_we    = pix_wr && (state_q == ST_IDLE);
    assign img_full  = &mask_q;
    assign busy      = (state_q == ST_STREAM) || (state_q == ST_WAIT);
    assign unused_wdata = ^REG_WDATA[31:8];

    // Per-pixel loaded flags: set by an accepted pixel write, wiped by CLEAR.
    genvar gi;
    generate
        for (gi = 0; gi < N_PIX; gi = gi + 1) begin : g_mask
            assign mask_d[gi] = !clear_req &&
                                (mask_q[gi] || (img_we && (REG_ADDR[7:0] == 8'(gi))));
        end
    endgenerate

    // Image store has no reset so it can map onto block RAM.
    always_ff @(posedge ACLK) begin
        if (img_we) begin
            img_mem[REG_ADDR[7:0]] <= REG_WDATA[7:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        to_flag_d   = to_flag_q;
        res_valid_d = RES_RD ? 1'b0 : res_valid_q;
        digit_d     = digit_q;
        snn_start_d = 1'b0;
        pix_idx_d   = pix_idx_q;
        cnt_d       = cnt_q;
        seen_low_d  = seen_low_q;
        rd_en       = 1'b0;
        rd_addr     = pix_idx_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_req) begin
                    if (img_full) begin
                        state_d     = ST_STREAM;
                        snn_start_d = 1'b1;
                        pix_idx_d   = 8'd0;
                        rd_en       = 1'b1;
                        rd_addr     = 8'd0;
                        err_d       = 1'b0;
                        to_flag_d   = 1'b0;
                        cnt_d       = 16'd0;
                        seen_low_d  = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_STREAM, ST_WAIT: begin
                if (pix_wr) begin
                    err_d = 1'b1;
                end
                if (!COPROCESSOR_RDY) begin
                    seen_low_d = 1'b1;
                end
                if (state_q == ST_STREAM) begin
                    if (PIX_READY) begin
                        if (pix_idx_q == LAST_IDX) begin
                            state_d = ST_WAIT;
                        end else begin
                            // Prefetch the next pixel so PIX_VAL tracks PIX_IDX.
                            pix_idx_d = pix_idx_q + 8'd1;
                            rd_en     = 1'b1;
                            rd_addr   = pix_idx_q + 8'd1;
                        end
                    end
                end else if (COPROCESSOR_RDY && seen_low_q) begin
                    // RDY must have dropped first, otherwise a stale idle
                    // level would be mistaken for completion.
                    digit_d     = INFERED_DIGIT;
                    res_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
                // A capture in the final counted cycle still wins.
                if (state_d != ST_DONE) begin
                    if (cnt_q == TO_LAST) begin
                        state_d   = ST_IDLE;
                        err_d     = 1'b1;
                        to_flag_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (clear_req) begin
            state_d     = ST_IDLE;
            err_d       = 1'b0;
            to_flag_d   = 1'b0;
            res_valid_d = 1'b0;
            snn_start_d = 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            digit_q     <= 8'd0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
            to_flag_q   <= 1'b0;
            snn_start_q <= 1'b0;
            pix_idx_q   <= 8'd0;
            pix_val_q   <= 8'd0;
            cnt_q       <= 16'd0;
            seen_low_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            digit_q     <= digit_d;
            res_valid_q <= res_valid_d;
            err_q       <= err_d;
            to_flag_q   <= to_flag_d;
            snn_start_q <= snn_start_d;
            pix_idx_q   <= pix_idx_d;
            cnt_q       <= cnt_d;
            seen_low_q  <= seen_low_d;
            if (rd_en) begin
                pix_val_q <= img_mem[rd_addr];
            end
        end
    end

    assign STATUS    = {19'd0, to_flag_q, img_full, err_q, busy, res_valid_q, digit_q};
    assign SNN_START = snn_start_q;
    assign PIX_VALID = (state_q == ST_STREAM);
    assign PIX_IDX   = pix_idx_q;
    assign PIX_VAL   = pix_val_q;

endmodule

// File: tb/tb_snn_infer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_snn_infer_ctrl
//
// Transaction-level bench for snn_infer_ctrl. A reference model holds the
// image, the loaded flags and the host-visible flags; expected STATUS words
// and expected pixel streams are derived from it. A second instance with a
// short abort limit and a coprocessor that never goes busy exercises the
// timeout path.
// -----------------------------------------------------------------------------
module tb_snn_infer_ctrl;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic        REG_WE;
    logic [8:0]  REG_ADDR;
    logic [31:0] REG_WDATA;
    logic        RES_RD;
    logic        PIX_READY;
    logic        COPROCESSOR_RDY;
    logic [7:0]  INFERED_DIGIT;
    logic [31:0] STATUS;
    logic        SNN_START;
    logic        PIX_VALID;
    logic [7:0]  PIX_IDX;
    logic [7:0]  PIX_VAL;

    logic [31:0] to_status;
    logic        to_snn_start;
    logic        to_pix_valid;
    logic [7:0]  to_pix_idx;
    logic [7:0]  to_pix_val;
    logic        to_rdy;
    assign to_rdy = 1'b1;

    always #5 ACLK = ~ACLK;

    snn_infer_ctrl #(.N_PIX(256), .TIMEOUT(2000)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .REG_WE(REG_WE), .REG_ADDR(REG_ADDR),
        .REG_WDATA(REG_WDATA), .RES_RD(RES_RD), .STATUS(STATUS),
        .SNN_START(SNN_START), .PIX_VALID(PIX_VALID), .PIX_IDX(PIX_IDX),
        .PIX_VAL(PIX_VAL), .PIX_READY(PIX_READY),
        .COPROCESSOR_RDY(COPROCESSOR_RDY), .INFERED_DIGIT(INFERED_DIGIT)
    );

    snn_infer_ctrl #(.N_PIX(256), .TIMEOUT(100)) dut_to (
        .ACLK(ACLK), .ARESETN(ARESETN), .REG_WE(REG_WE), .REG_ADDR(REG_ADDR),
        .REG_WDATA(REG_WDATA), .RES_RD(RES_RD), .STATUS(to_status),
        .SNN_START(to_snn_start), .PIX_VALID(to_pix_valid), .PIX_IDX(to_pix_idx),
        .PIX_VAL(to_pix_val), .PIX_READY(PIX_READY),
        .COPROCESSOR_RDY(to_rdy), .INFERED_DIGIT(8'd0)
    );

    int checks_cnt = 0;
    int errors_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] img_m [256];
    bit         mask_m [256];
    bit         err_m, to_m, rv_m;
    logic [7:0] digit_m;

    function automatic logic [31:0] exp_status(input bit busy);
        bit full;
        full = 1'b1;
        for (int i = 0; i < 256; i++) if (!mask_m[i]) full = 1'b0;
        return {19'd0, to_m, full, err_m, busy, rv_m, digit_m};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) mask_m[i] = 1'b0;
        err_m = 1'b0; to_m = 1'b0; rv_m = 1'b0; digit_m = 8'd0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) mask_m[i] = 1'b0;
        err_m = 1'b0; to_m = 1'b0; rv_m = 1'b0;
    endtask

    // ---------------- stream monitor ----------------
    logic [15:0] beat_q [$];
    int          start_pulses = 0;
    bit          stab_en = 1'b0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_idx, prev_val;

    always @(negedge ACLK) begin
        if (SNN_START) start_pulses++;
        if (stab_en && prev_stall) begin
            check_val("stall_valid", PIX_VALID, 1);
            check_val("stall_idx", PIX_IDX, prev_idx);
            check_val("stall_val", PIX_VAL, prev_val);
        end
        prev_stall = PIX_VALID && !PIX_READY;
        prev_idx   = PIX_IDX;
        prev_val   = PIX_VAL;
        if (PIX_VALID && PIX_READY) beat_q.push_back({PIX_IDX, PIX_VAL});
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic reg_write(input logic [8:0] addr, input logic [31:0] data);
        REG_WE = 1'b1; REG_ADDR = addr; REG_WDATA = data;
        tick();
        REG_WE = 1'b0; REG_ADDR = 9'd0; REG_WDATA = 32'd0;
    endtask

    task automatic write_pixel(input logic [7:0] idx, input logic [7:0] val);
        reg_write({1'b0, idx}, {24'($urandom()), val});
        img_m[idx]  = val;
        mask_m[idx] = 1'b1;
    endtask

    task automatic load_random_image();
        for (int i = 0; i < 256; i++) write_pixel(8'(i), 8'($urandom()));
        $display("[%0t] image loaded with random pixels", $time);
    endtask

    task automatic run_infer(input bit rand_rdy, input logic [7:0] digit, input int low_cycles,
                             input bit busy_write, input bit start_busy, input bit rd_capture);
        int n0;
        int cyc;
        beat_q.delete();
        n0 = start_pulses;
        PIX_READY = 1'b1;
        COPROCESSOR_RDY = 1'b1;
        reg_write(9'd256, ($urandom() & 32'hFFFF_FFFC) | 32'h1);
        err_m = 1'b0; to_m = 1'b0;
        check_val("start_pulse", SNN_START, 1);
        check_val("start_valid", PIX_VALID, 1);
        check_val("start_idx", PIX_IDX, 0);
        check_val("start_val", PIX_VAL, img_m[0]);
        check_val("start_status", STATUS, exp_status(1));
        COPROCESSOR_RDY = 1'b0;
        stab_en = rand_rdy;
        cyc = 0;
        while (PIX_VALID === 1'b1 && cyc < 3000) begin
            if (rand_rdy) PIX_READY = 1'($urandom_range(0, 1));
            if (busy_write && cyc == 3) begin
                REG_WE = 1'b1; REG_ADDR = 9'd200; REG_WDATA = {24'd0, ~img_m[200]};
                err_m = 1'b1;
            end
            if (start_busy && cyc == 5) begin
                REG_WE = 1'b1; REG_ADDR = 9'd256; REG_WDATA = 32'h1;
            end
            tick();
            REG_WE = 1'b0; REG_ADDR = 9'd0; REG_WDATA = 32'd0;
            if ((busy_write && cyc == 3) || (start_busy && cyc == 5))
                check_val("busy_write_status", STATUS, exp_status(1));
            cyc++;
        end
        stab_en = 1'b0;
        PIX_READY = 1'b0;
        check_val("stream_done", PIX_VALID, 0);
        check_val("wait_status", STATUS, exp_status(1));
        repeat (low_cycles) tick();
        check_val("wait_hold", STATUS, exp_status(1));
        INFERED_DIGIT = digit;
        COPROCESSOR_RDY = 1'b1;
        RES_RD = rd_capture;
        tick();
        RES_RD = 1'b0;
        INFERED_DIGIT = ~digit;
        rv_m = 1'b1; digit_m = digit;
        check_val("capture_status", STATUS, exp_status(0));
        tick();
        check_val("after_done_status", STATUS, exp_status(0));
        check_val("start_count", start_pulses - n0, 1);
        check_val("beat_count", beat_q.size(), 256);
        for (int i = 0; i < beat_q.size() && i < 256; i++) begin
            check_val("beat_idx", beat_q[i][15:8], i);
            check_val("beat_val", beat_q[i][7:0], img_m[i]);
        end
        $display("[%0t] inference done: %0d beats, digit %0d", $time, beat_q.size(), STATUS[7:0]);
        RES_RD = 1'b1;
        tick();
        RES_RD = 1'b0;
        rv_m = 1'b0;
        check_val("res_rd_clear", STATUS, exp_status(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        int cyc;
        ARESETN = 1'b0; REG_WE = 1'b0; REG_ADDR = 9'd0; REG_WDATA = 32'd0;
        RES_RD = 1'b0; PIX_READY = 1'b0; COPROCESSOR_RDY = 1'b1; INFERED_DIGIT = 8'd0;
        model_reset();
        repeat (3) tick();
        check_val("rst_status", STATUS, 0);
        check_val("rst_start", SNN_START, 0);
        check_val("rst_valid", PIX_VALID, 0);
        check_val("rst_idx", PIX_IDX, 0);
        check_val("rst_val", PIX_VAL, 0);
        ARESETN = 1'b1;
        tick();
        check_val("post_rst_status", STATUS, exp_status(0));

        // Partial image must refuse START.
        for (int i = 0; i < 255; i++) write_pixel(8'(i), 8'(i));
        $display("[%0t] 255 pixels loaded", $time);
        check_val("partial_status", STATUS, exp_status(0));
        reg_write(9'd256, 32'h1);
        err_m = 1'b1;
        check_val("start_notfull_pulse", SNN_START, 0);
        check_val("start_notfull_status", STATUS, exp_status(0));
        write_pixel(8'd255, 8'd255);
        check_val("full_status", STATUS, exp_status(0));

        // Out-of-range address carrying START|CLEAR bits is ignored.
        reg_write(9'(257 + $urandom_range(0, 254)), 32'h3);
        check_val("bad_addr_pulse", SNN_START, 0);
        check_val("bad_addr_status", STATUS, exp_status(0));

        run_infer(1'b0, 8'd7, 10, 1'b0, 1'b0, 1'b0);
        load_random_image();
        run_infer(1'b1, 8'($urandom()), int'($urandom_range(1, 30)), 1'b1, 1'b0, 1'b0);
        // Repeat START reuses the retained image.
        run_infer(1'b1, 8'($urandom()), int'($urandom_range(1, 30)), 1'b0, 1'b1, 1'b1);

        // START together with CLEAR: CLEAR wins.
        reg_write(9'd256, 32'h3);
        model_clear();
        check_val("clr_start_pulse", SNN_START, 0);
        check_val("clr_start_status", STATUS, exp_status(0));
        $display("[%0t] clear with start", $time);

        // Abort path on the short-limit instance.
        load_random_image();
        PIX_READY = 1'b0;
        reg_write(9'd256, 32'h1);
        err_m = 1'b0; to_m = 1'b0;
        check_val("to_start_pulse", to_snn_start, 1);
        repeat (99) tick();
        check_val("to_busy_at_99", to_status[9], 1);
        tick();
        check_val("to_abort_status", to_status, 32'h0000_1C00);
        check_val("to_abort_valid", to_pix_valid, 0);
        $display("[%0t] timeout instance aborted", $time);

        // CLEAR in mid-stream on the main instance.
        PIX_READY = 1'b1;
        cyc = 0;
        while (PIX_IDX !== 8'd40 && cyc < 200) begin
            tick();
            cyc++;
        end
        check_val("reach_idx40", PIX_IDX, 40);
        check_val("idx40_val", PIX_VAL, img_m[40]);
        reg_write(9'd256, 32'h2);
        model_clear();
        check_val("mid_clear_valid", PIX_VALID, 0);
        check_val("mid_clear_status", STATUS, exp_status(0));
        reg_write(9'd256, 32'h1);
        err_m = 1'b1;
        check_val("start_after_clear_pulse", SNN_START, 0);
        check_val("start_after_clear_status", STATUS, exp_status(0));
        $display("[%0t] mid-stream clear", $time);

        // Asynchronous reset while waiting for the coprocessor.
        load_random_image();
        PIX_READY = 1'b1;
        COPROCESSOR_RDY = 1'b1;
        reg_write(9'd256, 32'h1);
        err_m = 1'b0; to_m = 1'b0;
        COPROCESSOR_RDY = 1'b0;
        cyc = 0;
        while (PIX_VALID === 1'b1 && cyc < 400) begin
            tick();
            cyc++;
        end
        check_val("pre_rst_wait_status", STATUS, exp_status(1));
        #2;
        ARESETN = 1'b0;
        #1;
        check_val("async_rst_status", STATUS, 0);
        check_val("async_rst_start", SNN_START, 0);
        check_val("async_rst_valid", PIX_VALID, 0);
        check_val("async_rst_idx", PIX_IDX, 0);
        check_val("async_rst_val", PIX_VAL, 0);
        tick();
        ARESETN = 1'b1;
        model_reset();
        tick();
        check_val("post_rst2_status", STATUS, exp_status(0));
        check_val("post_rst2_valid", PIX_VALID, 0);
        $display("[%0t] reset during wait", $time);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
